// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT stage sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Ceiling log2, usable in parameter/port width expressions.
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Distance between the two butterfly inputs in stage s of a 2^n_log2 transform.
    function automatic int stage_span(input int n_log2, input int s);
        return 1 << (n_log2 - 1 - s);
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous active-low clear.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // Shift one slot per cycle; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Stage sequencer / address generator for an in-place radix-2 DIF FFT
// running over a ping-pong RAM pair. One butterfly pair is read per cycle;
// its results are written PIPE_LAT cycles later to the opposite bank.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2   = 10,
    parameter int PIPE_LAT = 4,
    parameter bit INIT_SEL = 1'b0,
    localparam int SW      = (clog2(N_LOG2) < 1) ? 1 : clog2(N_LOG2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ram_select,
    output logic [N_LOG2-1:0] addr_read_0,
    output logic [N_LOG2-1:0] addr_read_1,
    output logic [N_LOG2-1:0] addr_write_0,
    output logic [N_LOG2-1:0] addr_write_1,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic              rd_valid,
    output logic [N_LOG2-2:0] tw_idx,
    output logic [SW-1:0]     stage,
    output logic              busy,
    output logic              done
);

    localparam int KW = N_LOG2 - 1;   // pair counter width, N/2 pairs per stage

    state_t          state, state_nxt;
    logic [KW-1:0]   k;
    logic [4:0]      drain_cnt;
    logic [SW-1:0]   stage_q;
    logic            sel_q;
    logic            last_k, drain_last, last_stage;

    logic [N_LOG2-1:0] kx, span_n, mask, ix, jx;
    logic [KW-1:0]     twx;
    logic              wr_vld;

    assign last_k     = &k;
    assign drain_last = (drain_cnt == 5'(PIPE_LAT - 1));
    assign last_stage = (stage_q == SW'(N_LOG2 - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: run N/2 pairs, drain the pipe, repeat per stage, then finish.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_k) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_last) state_nxt = last_stage ? S_DONE : S_RUN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pair/drain counters, stage number and bank select. The bank flips only
    // once the last write of a stage has gone out, including after the final
    // stage, so the result ends up in the bank the unloader reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k         <= '0;
            drain_cnt <= '0;
            stage_q   <= '0;
            sel_q     <= INIT_SEL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k       <= '0;
                        stage_q <= '0;
                        sel_q   <= INIT_SEL;
                    end
                end
                S_RUN: begin
                    k         <= k + KW'(1);   // wraps to 0 after the last pair
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        drain_cnt <= '0;
                        sel_q     <= ~sel_q;
                        if (!last_stage) stage_q <= stage_q + SW'(1);
                    end else begin
                        drain_cnt <= drain_cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pair addressing: i is k with a zero spliced in at the span bit, j = i | span.
    always_comb begin
        kx     = {1'b0, k};
        span_n = N_LOG2'(stage_span(N_LOG2, int'(stage_q)));
        mask   = span_n - N_LOG2'(1);
        ix     = ((kx & ~mask) << 1) | (kx & mask);
        jx     = ix | span_n;
        twx    = KW'(kx & mask) << stage_q;
    end

    // Outputs: read side is zeroed whenever no real pair is being issued.
    always_comb begin
        rd_valid    = (state == S_RUN);
        busy        = (state == S_RUN) || (state == S_DRAIN);
        done        = (state == S_DONE);
        ram_select  = sel_q;
        stage       = stage_q;
        addr_read_0 = rd_valid ? ix  : '0;
        addr_read_1 = rd_valid ? jx  : '0;
        tw_idx      = rd_valid ? twx : '0;
    end

    // Write side is the read side delayed by the RAM + butterfly latency.
    pipe_delay #(
        .WIDTH (2 * N_LOG2 + 1),
        .DEPTH (PIPE_LAT)
    ) u_wr_pipe (
        .clk   (clk),
        .clr_n (rst_n),
        .din   ({rd_valid, addr_read_1, addr_read_0}),
        .dout  ({wr_vld, addr_write_1, addr_write_0})
    );

    assign wr_en_a = wr_vld;
    assign wr_en_b = wr_vld;

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
Sequencer and address generator for the in-place radix-2 DIF FFT. It drives the ping-pong RAM pair: it reads one butterfly pair per cycle from the read bank and writes the results to the write bank PIPE_LAT cycles later. It toggles ram_select between stages and supplies the twiddle index to the butterfly datapath. It sits upstream of the ping-pong RAM (address/enable/select side) and beside the butterfly unit.

Parameters:
N_LOG2, 10, log2 of FFT length N; equals the RAM address width (N = RAM depth)
PIPE_LAT, 4, cycles from read address presented to write of the same pair (RAM read latency + butterfly latency); range 1..16
INIT_SEL, 0, ram_select value during stage 0

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a transform (sampled only in IDLE)
ram_select  out  1  bank select (1: read bank 0, write bank 1; 0: the reverse)
addr_read_0  out  N_LOG2  read address, upper butterfly input (index i)
addr_read_1  out  N_LOG2  read address, lower butterfly input (index j)
addr_write_0  out  N_LOG2  write address for result 0 (i, delayed)
addr_write_1  out  N_LOG2  write address for result 1 (j, delayed)
wr_en_a  out  1  write enable, port 0 (fans out to both banks' port-0 enables)
wr_en_b  out  1  write enable, port 1 (fans out to both banks' port-1 enables)
rd_valid  out  1  read address this cycle is a real butterfly pair
tw_idx  out  N_LOG2-1  twiddle ROM index, aligned with addr_read_*
stage  out  clog2(N_LOG2)  current stage number
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset values: ram_select=INIT_SEL, all addresses 0, wr_en_a/b=0, rd_valid=0, tw_idx=0, stage=0, busy=0, done=0, state=IDLE, delay pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start → RUN, k=0, stage=0, ram_select=INIT_SEL.
  - RUN: issues N/2 pairs, k=0..N/2-1, one per cycle; after k=N/2-1 → DRAIN.
  - DRAIN: PIPE_LAT cycles with rd_valid=0. Then, if stage<N_LOG2-1: stage++, toggle ram_select, → RUN. Otherwise → DONE.
  - DONE: one cycle; done=1, busy=0, ram_select toggles once more → IDLE.
- Let H=N/2, L=PIPE_LAT, and let start be sampled at cycle t.
  - Stage s, pair k is read at cycle t+1+s(H+L)+k.
  - It is written at that cycle +L.
  - done is at cycle t+N_LOG2(H+L)+1.
- Address rule for stage s, with span=2^(N_LOG2-1-s):
  - i = k with a 0 bit inserted at bit position N_LOG2-1-s.
  - j = i | span.
  - tw_idx = (k mod span) << s, truncated to N_LOG2-1 bits.
- Write path: addr_write_0/1 = addr_read_0/1 delayed exactly L cycles. wr_en_a = wr_en_b = rd_valid delayed L cycles. Both ports always write together.
- ram_select is constant from the first read of a stage through its last write. It changes only on the cycle after the final drain write. No read of stage s+1 overlaps any write of stage s.
- Final ram_select = INIT_SEL ^ N_LOG2[0], so the result bank is the read bank for the unloader. It holds until the next start. Output is in bit-reversed order.
- start while busy or in DONE: ignored.
- Reset mid-transform: on the next edge everything returns to reset values. In-flight writes are discarded (wr_en forced 0), and no done is produced.

Decomposition:
- fft_pkg holds the state enum, the clog2 function, and the per-stage span computation helper.
- One sub-module, pipe_delay (WIDTH, DEPTH): a shift register with synchronous active-low clear. It delays {rd_valid, addr_read_1, addr_read_0} by PIPE_LAT.

Test Plan (N_LOG2=3, PIPE_LAT=2, INIT_SEL=0, start at cycle 0):
- Stage 0: cycles 1-4 read (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3 and ram_select=0. Writes go to the same pairs at cycles 3-6 with wr_en_a=wr_en_b=1.
- Stage 1: cycles 7-10 read (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2. ram_select=1 from cycle 7.
- Stage 2: cycles 13-16 read (0,1),(2,3),(4,5),(6,7) with tw 0. ram_select=0. The last write is at cycle 18. At cycle 19: done=1, busy=0, ram_select=1 afterwards.
- start pulsed again at cycle 10 (while busy): no effect; the schedule is identical to the scenarios above.
- rst_n=0 at cycle 8: from cycle 9, wr_en=0, busy=0, ram_select=0, and no done pulse. A new start at cycle 12 repeats the stage-0 sequence from cycle 13.
- Back-to-back transforms: start one cycle after done. Stage 0 uses ram_select=0 again, and no wr_en is asserted between done and the first new write.
